seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Pattern sequencer controller for the icestick button/LED sequencer. It owns the small pattern BRAM and schedules its write port (step recording from the debounced set button) and read port (tick-paced playback to the LEDs). It tracks the recorded length and runs an IDLE/READY/PLAY state machine. Playback can be started, stopped and cleared.

## Interface
- DEPTH_W, 4, address width; capacity = 2**DEPTH_W steps
- DATA_W, 2, pattern width per step (LED count)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick  in  1  one-cycle playback pulse from the clock divider
- rec  in  1  one-cycle pulse: record pat_in as the next step
- pat_in  in  DATA_W  live (level) pattern buttons
- play_tgl  in  1  one-cycle pulse: start/stop playback
- clr  in  1  one-cycle pulse: erase the sequence
- mem_w_en  out  1  pattern RAM write enable
- mem_w_addr  out  DEPTH_W  write address
- mem_w_data  out  DATA_W  write data
- mem_r_en  out  1  read enable
- mem_r_addr  out  DEPTH_W  read address
- mem_r_data  in  DATA_W  registered RAM output, valid one cycle after mem_r_en
- out  out  DATA_W  pattern to LEDs
- len  out  DEPTH_W+1  recorded step count, 0..2**DEPTH_W
- full  out  1  len == 2**DEPTH_W
- playing  out  1  state == PLAY

## Operation
- States:
  - IDLE: len==0.
  - READY: len>0, stopped.
  - PLAY: playback running.
- Reset: state=IDLE, len=0, ptr=0, out=0, rd_pend=0. All write/read strobes are 0.
- Priority per cycle: clr > play_tgl > rec > tick.
- clr, any state: go to IDLE; len=0; ptr=0; out=0; rd_pend=0. RAM contents are left stale.
- rec in IDLE/READY with !full:
  - mem_w_en=1, mem_w_addr=len[DEPTH_W-1:0], mem_w_data=pat_in, all in the same cycle (combinational).
  - len increments; IDLE goes to READY.
- rec while full or in PLAY is ignored: no write, len unchanged.
- play_tgl:
  - READY goes to PLAY with ptr=0.
  - PLAY goes to READY; out holds its last value.
  - In IDLE it is ignored.
- tick in PLAY:
  - mem_r_en=1 and mem_r_addr=ptr (combinational); set rd_pend.
  - ptr becomes (ptr==len-1) ? 0 : ptr+1. Compare at width DEPTH_W+1; no truncation.
- rd_pend set: on the next edge out<=mem_r_data and rd_pend clears. This completes even if play_tgl stopped playback in between. It does not complete if clr occurred.
- tick outside PLAY is ignored. Ticks arriving every cycle are legal: the pipeline is one read per tick, with no stall.
- len==1 in PLAY: ptr stays 0 and the same step re-reads on every tick.

## Timing
- Write: combinational strobe in the rec cycle; len is visible the following cycle.
- Playback latency: tick sampled at edge N; RAM registers data at edge N (mem_r_en high during cycle N-1..N); out updates at edge N+1. The value is visible 2 cycles after the tick cycle begins.
- play_tgl start: the first tick after the transition reads step 0.
- full and playing are registered/derived from registers; there is no combinational path from inputs to them.

## Configuration
- SEQ_CTRL_ONESHOT_EN:
  - Defined: after the read of step len-1 is issued, state returns to READY instead of wrapping. ptr resets to 0, and out keeps the last step once it lands.
  - Undefined: playback loops indefinitely.

## Structure
- Shared package/include seq_pkg:
  - state encodings S_IDLE=2'd0, S_READY=2'd1, S_PLAY=2'd2.
  - Default DEPTH_W/DATA_W constants, shared with the memory and top.
- One sub-module: seq_ptr, the playback pointer with wrap/oneshot terminal detect. The FSM, len counter and output register stay in seq_ctrl.
- The pattern RAM, debouncers and clock divider remain external.

## Test plan
- Reset, then rec with pat_in=2'b01 then 2'b10 -> writes at addresses 0 and 1, len=2, state READY, full=0.
- play_tgl, then ticks with gaps -> out sequence 01,10,01,10, each landing 2 cycles after its tick; mem_r_addr 0,1,0,1.
- Record 16 steps (DEPTH_W=4) -> full=1, len=16; a 17th rec produces no mem_w_en and len stays 16. Playback then wraps 15->0.
- clr and rec in the same cycle during READY -> IDLE, len=0, out=0, no write. Then play_tgl is ignored (playing=0).
- play_tgl coincident with tick in PLAY -> stop takes priority, no read issued, out unchanged. rec during PLAY -> no write.
- With SEQ_CTRL_ONESHOT_EN and len=3: ticks produce out 0→s0,s1,s2, then READY. A fourth tick does nothing and out stays s2.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the pattern sequencer: default geometry and FSM encodings.
package seq_pkg;

   localparam int DEPTH_W_DEF = 4;
   localparam int DATA_W_DEF  = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READY = 2'd1;
   localparam logic [1:0] S_PLAY  = 2'd2;

endpackage

// File: rtl/seq_ptr.sv
// Playback pointer: restarts at step 0, advances once per issued read and wraps
// after the last recorded step; `last` flags the terminal step for one-shot stop.
module seq_ptr
   import seq_pkg::*;
#(
   parameter int DEPTH_W = DEPTH_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               restart,
   input  logic               advance,
   input  logic [DEPTH_W:0]   len,
   output logic [DEPTH_W-1:0] ptr,
   output logic               last
);

   localparam int LEN_W = DEPTH_W + 1;

   // Compared at full length width so len == 2**DEPTH_W still terminates at the top address.
   assign last = ({1'b0, ptr} == (len - LEN_W'(1)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (restart) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= last ? '0 : ptr + DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/seq_ctrl.sv
// Pattern sequencer controller: schedules the pattern RAM write (record) and read
// (tick-paced playback) ports. Optional one-shot playback: SEQ_CTRL_ONESHOT_EN.
//
// state   | meaning
// S_IDLE  | nothing recorded (len == 0)
// S_READY | steps recorded, playback stopped
// S_PLAY  | playback running, one RAM read per tick
module seq_ctrl
   import seq_pkg::*;
#(
   parameter int DEPTH_W = DEPTH_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               rec,
   input  logic [DATA_W-1:0]  pat_in,
   input  logic               play_tgl,
   input  logic               clr,
   output logic               mem_w_en,
   output logic [DEPTH_W-1:0] mem_w_addr,
   output logic [DATA_W-1:0]  mem_w_data,
   output logic               mem_r_en,
   output logic [DEPTH_W-1:0] mem_r_addr,
   input  logic [DATA_W-1:0]  mem_r_data,
   output logic [DATA_W-1:0]  out,
   output logic [DEPTH_W:0]   len,
   output logic               full,
   output logic               playing
);

   localparam int LEN_W = DEPTH_W + 1;
   localparam logic [LEN_W-1:0] CAP = LEN_W'(2**DEPTH_W);

`ifdef SEQ_CTRL_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   logic [1:0]         state;
   logic               rd_pend;
   logic [DEPTH_W-1:0] ptr;
   logic               ptr_last;
   logic               is_play;
   logic               tgl_act;
   logic               rec_act;
   logic               tick_act;
   logic               start;

   assign is_play  = (state == S_PLAY);
   assign full     = (len == CAP);
   assign playing  = is_play;

   // clr masks everything, play_tgl masks rec and tick
   assign tgl_act  = !clr && play_tgl;
   assign rec_act  = !clr && !play_tgl && rec && !is_play && !full;
   assign tick_act = !clr && !play_tgl && tick && is_play;
   assign start    = tgl_act && (state == S_READY);

   assign mem_w_en   = rec_act;
   assign mem_w_addr = len[DEPTH_W-1:0];
   assign mem_w_data = pat_in;
   assign mem_r_en   = tick_act;
   assign mem_r_addr = ptr;

   seq_ptr #(.DEPTH_W(DEPTH_W)) u_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (clr || start),
      .advance (tick_act),
      .len     (len),
      .ptr     (ptr),
      .last    (ptr_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         len     <= '0;
         out     <= '0;
         rd_pend <= 1'b0;
      end else if (clr) begin
         state   <= S_IDLE;
         len     <= '0;
         out     <= '0;
         rd_pend <= 1'b0;
      end else begin
         // an in-flight read still lands after a stop
         rd_pend <= tick_act;
         if (rd_pend) begin
            out <= mem_r_data;
         end
         if (rec_act) begin
            len <= len + LEN_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (rec_act) begin
                  state <= S_READY;
               end
            end
            S_READY: begin
               if (tgl_act) begin
                  state <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (tgl_act) begin
                  state <= S_READY;
               end else if (tick_act && ONESHOT && ptr_last) begin
                  state <= S_READY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: external RAM model, per-cycle step-level reference model,
// and directed scenarios with literal expectations. Honours SEQ_CTRL_ONESHOT_EN.
module tb_seq_ctrl;

   localparam int DEPTH_W = 4;
   localparam int DATA_W  = 2;
   localparam int CAP     = 16;

`ifdef SEQ_CTRL_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               tick = 1'b0;
   logic               rec = 1'b0;
   logic [DATA_W-1:0]  pat_in = '0;
   logic               play_tgl = 1'b0;
   logic               clr = 1'b0;
   logic               mem_w_en;
   logic [DEPTH_W-1:0] mem_w_addr;
   logic [DATA_W-1:0]  mem_w_data;
   logic               mem_r_en;
   logic [DEPTH_W-1:0] mem_r_addr;
   logic [DATA_W-1:0]  mem_r_data = '0;
   logic [DATA_W-1:0]  out;
   logic [DEPTH_W:0]   len;
   logic               full;
   logic               playing;

   int checks = 0;
   int errors = 0;

   seq_ctrl #(.DEPTH_W(DEPTH_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .rec        (rec),
      .pat_in     (pat_in),
      .play_tgl   (play_tgl),
      .clr        (clr),
      .mem_w_en   (mem_w_en),
      .mem_w_addr (mem_w_addr),
      .mem_w_data (mem_w_data),
      .mem_r_en   (mem_r_en),
      .mem_r_addr (mem_r_addr),
      .mem_r_data (mem_r_data),
      .out        (out),
      .len        (len),
      .full       (full),
      .playing    (playing)
   );

   always #5 clk = ~clk;

   // external pattern RAM with registered read, plus address logs
   logic [DATA_W-1:0] ram [CAP];
   int wlog[$];
   int rlog[$];
   always @(posedge clk) begin
      if (mem_w_en) begin
         ram[mem_w_addr] <= mem_w_data;
         wlog.push_back(int'(mem_w_addr));
      end
      if (mem_r_en) begin
         mem_r_data <= ram[mem_r_addr];
         rlog.push_back(int'(mem_r_addr));
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: recorded steps, play flag, position, delayed delivery
   int         m_len, m_pos;
   bit         m_play, m_pend;
   int         m_out, m_pend_val;
   int         m_steps[CAP];
   bit         w_exp, r_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_len = 0; m_pos = 0; m_play = 0; m_pend = 0; m_out = 0; m_pend_val = 0;
      end else begin
         w_exp = !clr && !play_tgl && rec && !m_play && (m_len < CAP);
         r_exp = !clr && !play_tgl && tick && m_play;
         chk("mem_w_en", int'(mem_w_en), int'(w_exp));
         if (w_exp) begin
            chk("mem_w_addr", int'(mem_w_addr), m_len);
            chk("mem_w_data", int'(mem_w_data), int'(pat_in));
         end
         chk("mem_r_en", int'(mem_r_en), int'(r_exp));
         if (r_exp) chk("mem_r_addr", int'(mem_r_addr), m_pos);
         chk("out", int'(out), m_out);
         chk("len", int'(len), m_len);
         chk("full", int'(full), int'(m_len == CAP));
         chk("playing", int'(playing), int'(m_play));
         if (clr) begin
            m_len = 0; m_pos = 0; m_play = 0; m_pend = 0; m_out = 0;
         end else begin
            if (m_pend) begin
               m_out = m_pend_val;
               m_pend = 0;
            end
            if (play_tgl) begin
               if (m_play) m_play = 0;
               else if (m_len > 0) begin
                  m_play = 1;
                  m_pos = 0;
               end
            end else if (w_exp) begin
               m_steps[m_len] = int'(pat_in);
               m_len++;
            end else if (r_exp) begin
               m_pend = 1;
               m_pend_val = m_steps[m_pos];
               m_pos++;
               if (m_pos == m_len) begin
                  m_pos = 0;
                  if (ONESHOT) m_play = 0;
               end
            end
         end
      end
   end

   task automatic cyc(input bit c, input bit t, input bit r, input bit k, input logic [1:0] p);
      clr = c; play_tgl = t; rec = r; tick = k; pat_in = p;
      @(posedge clk); #1;
      clr = 0; play_tgl = 0; rec = 0; tick = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 2'b00);
   endtask

   int nw, nr;
   int exp_out[4];

   initial begin
      @(posedge clk); #1;
      idle(2);
      chk("rst_out", int'(out), 0);
      chk("rst_len", int'(len), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_playing", int'(playing), 0);
      chk("rst_w_en", int'(mem_w_en), 0);
      chk("rst_r_en", int'(mem_r_en), 0);
      rst_n = 1'b1;
      idle(1);

      // record two steps
      cyc(0, 0, 1, 0, 2'b01);
      cyc(0, 0, 1, 0, 2'b10);
      chk("rec2_len", int'(len), 2);
      chk("rec2_full", int'(full), 0);
      chk("rec2_playing", int'(playing), 0);
      chk("rec2_wcount", wlog.size(), 2);
      chk("rec2_waddr0", wlog[0], 0);
      chk("rec2_waddr1", wlog[1], 1);

`ifndef SEQ_CTRL_ONESHOT_EN
      exp_out = '{1, 2, 1, 2};
      cyc(0, 1, 0, 0, 2'b00);
      chk("start_playing", int'(playing), 1);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 1, 2'b00);
         chk("out_before_land", int'(out), (k == 0) ? 0 : exp_out[k-1]);
         cyc(0, 0, 0, 0, 2'b00);
         chk("out_landed", int'(out), exp_out[k]);
         idle(1);
      end
      chk("rd_count", rlog.size(), 4);
      chk("rd_addr_seq", rlog[0] * 1000 + rlog[1] * 100 + rlog[2] * 10 + rlog[3], 101);
      // stop coincident with tick: no read issued
      cyc(0, 1, 0, 1, 2'b00);
      chk("stop_playing", int'(playing), 0);
      chk("stop_no_read", rlog.size(), 4);
      idle(1);
      chk("stop_out_held", int'(out), 2);
      cyc(0, 1, 0, 0, 2'b00);
      cyc(0, 0, 1, 0, 2'b11);
      chk("rec_in_play_len", int'(len), 2);
      chk("rec_in_play_nowrite", wlog.size(), 2);
      cyc(0, 1, 0, 0, 2'b00);
`else
      cyc(0, 0, 1, 0, 2'b11);
      chk("os_len3", int'(len), 3);
      exp_out = '{1, 2, 3, 3};
      cyc(0, 1, 0, 0, 2'b00);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 1, 2'b00);
         cyc(0, 0, 0, 0, 2'b00);
         chk("os_out", int'(out), exp_out[k]);
         idle(1);
      end
      chk("os_playing", int'(playing), 0);
      chk("os_rd_count", rlog.size(), 3);
`endif

      // clr beats rec in READY, then play_tgl in IDLE ignored
      nw = wlog.size();
      cyc(1, 0, 1, 0, 2'b11);
      chk("clr_len", int'(len), 0);
      chk("clr_out", int'(out), 0);
      chk("clr_nowrite", wlog.size(), nw);
      cyc(0, 1, 0, 0, 2'b00);
      chk("idle_tgl_ignored", int'(playing), 0);

      // fill to capacity, 17th rec ignored
      for (int i = 0; i < CAP; i++) cyc(0, 0, 1, 0, 2'((3 * i) & 3));
      chk("full_flag", int'(full), 1);
      chk("full_len", int'(len), 16);
      nw = wlog.size();
      chk("full_last_waddr", wlog[nw-1], 15);
      cyc(0, 0, 1, 0, 2'b10);
      chk("full_nowrite", wlog.size(), nw);
      chk("full_len_hold", int'(len), 16);

      // back-to-back ticks across the wrap point
      cyc(0, 1, 0, 0, 2'b00);
      nr = rlog.size();
      for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 2'b00);
      idle(2);
`ifndef SEQ_CTRL_ONESHOT_EN
      chk("wrap_addr15", rlog[nr+15], 15);
      chk("wrap_addr0", rlog[nr+16], 0);
      chk("wrap_out", int'(out), 3);
      // pending read completes despite stop
      cyc(0, 0, 0, 1, 2'b00);
      cyc(0, 1, 0, 0, 2'b00);
      chk("stop_pend_out", int'(out), 2);
      chk("stop_pend_playing", int'(playing), 0);
`else
      chk("os_full_rd_count", rlog.size(), nr + 16);
      chk("os_full_playing", int'(playing), 0);
      chk("os_full_out", int'(out), 1);
`endif

      // clr drops an in-flight read
      cyc(0, 1, 0, 0, 2'b00);
      cyc(0, 0, 0, 1, 2'b00);
      cyc(0, 0, 0, 1, 2'b00);
      cyc(1, 0, 0, 0, 2'b00);
      chk("clr_pend_out", int'(out), 0);
      idle(1);
      chk("clr_pend_out2", int'(out), 0);
      chk("clr_pend_len", int'(len), 0);
      chk("clr_pend_playing", int'(playing), 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
